// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for branch resolution and predictor training
package branch_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } br_res_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } br_update_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_inc && (o_count != MAX)) begin
      o_count <= o_count + ONE;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - checks resolved branches against their prediction, trains the predictor, redirects fetch
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_res_valid,
  input  logic [31:0]      i_res_pc,
  input  logic             i_res_taken,
  input  logic [31:0]      i_res_target,
  input  logic             i_prd_taken,
  input  logic [31:0]      i_prd_target,
  output logic             o_br_update_valid,
  output logic [31:0]      o_br_update_pc,
  output logic [31:0]      o_br_update_target,
  output logic             o_br_update_taken,
  output logic             o_flush,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  input  logic             i_redirect_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt_branches,
  output logic [CNT_W-1:0] o_cnt_mispredicts
);

  br_res_state_e state, state_next;
  br_update_t    update;
  logic          accept;
  logic          mispredict;
  logic          accept_mis;
  logic [31:0]   correct_pc;
  logic          flush;
  logic [31:0]   redirect_pc;

  // While a redirect is pending everything arriving is wrong-path and ignored.
  always_comb begin
    accept     = i_res_valid && (state == IDLE);
    mispredict = (i_res_taken != i_prd_taken)
               | (i_res_taken & i_prd_taken & (i_res_target != i_prd_target));
    accept_mis = accept && mispredict;
    correct_pc = i_res_taken ? i_res_target : (i_res_pc + INSTR_BYTES);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept_mis) state_next = REDIRECT;
      REDIRECT: if (i_redirect_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      update      <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      update.valid <= accept;
      flush        <= accept_mis;
      if (accept) begin
        update.pc     <= i_res_pc;
        update.target <= i_res_target;
        update.taken  <= i_res_taken;
      end
      if (accept_mis) begin
        redirect_pc <= correct_pc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_branches (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (accept),
    .o_count (o_cnt_branches)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispredicts (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (accept_mis),
    .o_count (o_cnt_mispredicts)
  );

  // The state register doubles as the redirect-valid and busy flops.
  assign o_br_update_valid  = update.valid;
  assign o_br_update_pc     = update.pc;
  assign o_br_update_target = update.target;
  assign o_br_update_taken  = update.taken;
  assign o_flush            = flush;
  assign o_redirect_valid   = (state == REDIRECT);
  assign o_redirect_pc      = redirect_pc;
  assign o_busy             = (state == REDIRECT);

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - self-checking bench for branch_resolution_unit
module tb_branch_resolution_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             prd_taken;
  logic [31:0]      prd_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic             flush;
  logic             rv;
  logic [31:0]      rpc;
  logic             ready;
  logic             busy;
  logic [CNT_W-1:0] cnt_br;
  logic [CNT_W-1:0] cnt_mp;

  branch_resolution_unit #(.CNT_W(CNT_W)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_res_valid        (res_valid),
    .i_res_pc           (res_pc),
    .i_res_taken        (res_taken),
    .i_res_target       (res_target),
    .i_prd_taken        (prd_taken),
    .i_prd_target       (prd_target),
    .o_br_update_valid  (upd_valid),
    .o_br_update_pc     (upd_pc),
    .o_br_update_target (upd_target),
    .o_br_update_taken  (upd_taken),
    .o_flush            (flush),
    .o_redirect_valid   (rv),
    .o_redirect_pc      (rpc),
    .i_redirect_ready   (ready),
    .o_busy             (busy),
    .o_cnt_branches     (cnt_br),
    .o_cnt_mispredicts  (cnt_mp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        ptaken;
    logic [31:0] ptarget;
    logic        mis;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mis;
    logic [31:0] rpc;
    int          n_br;
    int          n_mp;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    res_valid  = v;
    res_pc     = pc;
    res_taken  = t;
    res_target = tgt;
    prd_taken  = pt;
    prd_target = ptgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
  endtask

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0100, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0104};
    vecs[2] = '{32'h0000_1000, 1'b1, 32'h0000_0340, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0340};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_2000, 1'b0, 32'h0000_0055, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_2004, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000};
    vecs[6] = '{32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0};

    rst = 1'b1;
    ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    chk("reset_upd_valid", 32'(upd_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt_br", 32'(cnt_br), 32'd0);
    rst = 1'b0;

    // Reset while a redirect is outstanding
    drive(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rv", 32'(rv), 32'd0);
    chk("async_rst_rpc", rpc, 32'd0);
    chk("async_rst_cnt_br", 32'(cnt_br), 32'd0);
    chk("async_rst_cnt_mp", 32'(cnt_mp), 32'd0);
    chk("async_rst_upd", 32'(upd_pc), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    chk("first_upd_valid", 32'(upd_valid), 32'd1);
    chk("first_upd_pc", upd_pc, 32'h100);
    chk("first_upd_target", upd_target, 32'h200);
    chk("first_upd_taken", 32'(upd_taken), 32'd1);
    chk("first_flush", 32'(flush), 32'd0);
    chk("first_cnt_br", 32'(cnt_br), 32'd1);

    // Direction mispredict with a stalled fetch
    do_reset();
    ready = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    chk("dir_flush", 32'(flush), 32'd1);
    chk("dir_rv", 32'(rv), 32'd1);
    chk("dir_rpc", rpc, 32'h104);
    chk("dir_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 32'h500 + 32'(i * 4), 1'b1, 32'h900, 1'b1, 32'h900);
      tick();
      chk("hold_flush", 32'(flush), 32'd0);
      chk("hold_upd_valid", 32'(upd_valid), 32'd0);
      chk("hold_rv", 32'(rv), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_rpc", rpc, 32'h104);
      chk("hold_cnt_br", 32'(cnt_br), 32'd1);
      chk("hold_cnt_mp", 32'(cnt_mp), 32'd1);
    end
    ready = 1'b1;
    drive(1'b1, 32'h600, 1'b1, 32'h900, 1'b1, 32'h900);
    tick();
    ready = 1'b0;
    chk("hs_rv", 32'(rv), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_drop_upd", 32'(upd_valid), 32'd0);
    chk("hs_drop_cnt", 32'(cnt_br), 32'd1);
    tick();
    chk("after_hs_upd", 32'(upd_valid), 32'd1);
    chk("after_hs_pc", upd_pc, 32'h600);
    chk("after_hs_cnt", 32'(cnt_br), 32'd2);

    // Back-to-back correct predictions
    drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    chk("b2b_0_valid", 32'(upd_valid), 32'd1);
    chk("b2b_0_pc", upd_pc, 32'h40);
    drive(1'b1, 32'h44, 1'b0, 32'h80, 1'b0, 32'h0);
    tick();
    chk("b2b_1_valid", 32'(upd_valid), 32'd1);
    chk("b2b_1_pc", upd_pc, 32'h44);
    chk("b2b_1_taken", 32'(upd_taken), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("b2b_end_valid", 32'(upd_valid), 32'd0);

    // Target mispredict, fetch always ready
    ready = 1'b1;
    drive(1'b1, 32'h1000, 1'b1, 32'h340, 1'b1, 32'h300);
    tick();
    chk("tgt_flush", 32'(flush), 32'd1);
    chk("tgt_rv", 32'(rv), 32'd1);
    chk("tgt_rpc", rpc, 32'h340);
    drive(1'b1, 32'h50, 1'b1, 32'h70, 1'b1, 32'h70);
    tick();
    chk("tgt_rv_fall", 32'(rv), 32'd0);
    chk("tgt_flush_fall", 32'(flush), 32'd0);
    chk("tgt_drop_upd", 32'(upd_valid), 32'd0);
    tick();
    chk("tgt_next_upd", 32'(upd_valid), 32'd1);
    chk("tgt_next_pc", upd_pc, 32'h50);

    // Table-driven resolves with scoreboard
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].ptaken, vecs[i].ptarget);
      exp_br = sat(exp_br + 1);
      if (vecs[i].mis) exp_mp = sat(exp_mp + 1);
      exp_q.push_back('{vecs[i].pc, vecs[i].target, vecs[i].taken, vecs[i].mis, vecs[i].rpc, exp_br, exp_mp});
      tick();
      e = exp_q.pop_front();
      chk("vec_upd_valid", 32'(upd_valid), 32'd1);
      chk("vec_upd_pc", upd_pc, e.pc);
      chk("vec_upd_target", upd_target, e.target);
      chk("vec_upd_taken", 32'(upd_taken), 32'(e.taken));
      chk("vec_flush", 32'(flush), 32'(e.mis));
      chk("vec_rv", 32'(rv), 32'(e.mis));
      if (e.mis) chk("vec_rpc", rpc, e.rpc);
      chk("vec_cnt_br", 32'(cnt_br), 32'(e.n_br));
      chk("vec_cnt_mp", 32'(cnt_mp), 32'(e.n_mp));
      if (e.mis) begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("vec_rv_fall", 32'(rv), 32'd0);
        chk("vec_busy_fall", 32'(busy), 32'd0);
      end
    end

    // Counter saturation
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    chk("sat_cnt_br", 32'(cnt_br), 32'hF);
    chk("sat_cnt_mp", 32'(cnt_mp), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
